// File: rtl/lib_switchblock_pkg.sv
// Shared constants and types for the unit-element DAC switch block.
// Element count and pointer width follow from the quantizer code width.
package lib_switchblock_pkg;

    localparam int INPUT_WIDTH  = 16;
    localparam int OUTPUT_WIDTH = 3;
    localparam int NUM_ELEMENTS = (2 ** OUTPUT_WIDTH) - 1;
    localparam int PTR_WIDTH    = $clog2(NUM_ELEMENTS);
    localparam int LEVEL_SHIFT  = INPUT_WIDTH - OUTPUT_WIDTH;

    typedef enum logic {
        DEM_DWA   = 1'b0,
        DEM_THERM = 1'b1
    } dem_mode_e;

    typedef logic [NUM_ELEMENTS-1:0] elem_vec_t;

    // Thermometer code: the low 'code' bits set, all others clear.
    function automatic elem_vec_t therm_mask(input logic [OUTPUT_WIDTH-1:0] code);
        elem_vec_t mask;
        mask = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            mask[i] = (i < int'(code));
        end
        return mask;
    endfunction

endpackage

// File: rtl/dwa_rotator.sv
// Combinational DWA core: rotates a k-element thermometer to start at ptr
// and computes the wrapped next start position.
module dwa_rotator
    import lib_switchblock_pkg::*;
(
    input  logic [OUTPUT_WIDTH-1:0] code,
    input  logic [PTR_WIDTH-1:0]    ptr,
    output logic [NUM_ELEMENTS-1:0] mask,
    output logic [PTR_WIDTH-1:0]    ptr_next
);

    elem_vec_t                   therm_s;
    logic [2*NUM_ELEMENTS-1:0]   doubled_s;
    logic [PTR_WIDTH:0]          sum_s;

    // Rotate-left within NUM_ELEMENTS bits: shift a doubled copy and keep the upper half.
    always_comb begin
        therm_s   = therm_mask(code);
        doubled_s = {therm_s, therm_s} << ptr;
        mask      = doubled_s[2*NUM_ELEMENTS-1 -: NUM_ELEMENTS];
    end

    // Pointer advance modulo NUM_ELEMENTS; the sum never reaches twice the modulus.
    always_comb begin
        sum_s = (PTR_WIDTH+1)'(ptr) + (PTR_WIDTH+1)'(code);
        if (sum_s >= (PTR_WIDTH+1)'(NUM_ELEMENTS)) begin
            ptr_next = PTR_WIDTH'(sum_s - (PTR_WIDTH+1)'(NUM_ELEMENTS));
        end else begin
            ptr_next = sum_s[PTR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dwa_element_selector.sv
// DWA element selector: decodes quantizer codes into rotated unit-element
// enables (or a static thermometer) and reports the ideal reconstructed level.
module dwa_element_selector
    import lib_switchblock_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [OUTPUT_WIDTH-1:0] code_i,
    input  logic                    mode_i,
    output logic [NUM_ELEMENTS-1:0] elements_o,
    output logic                    valid_o,
    output logic [INPUT_WIDTH-1:0]  level_o,
    output logic [PTR_WIDTH-1:0]    ptr_o
);

    elem_vec_t               elements_r;
    logic [INPUT_WIDTH-1:0]  level_r;
    logic [PTR_WIDTH-1:0]    ptr_r;
    logic                    valid_r;

    elem_vec_t               elements_nxt_s;
    logic [INPUT_WIDTH-1:0]  level_nxt_s;
    logic [PTR_WIDTH-1:0]    ptr_nxt_s;
    logic                    valid_nxt_s;

    elem_vec_t               rot_mask_s;
    logic [PTR_WIDTH-1:0]    rot_ptr_next_s;
    dem_mode_e               mode_s;

    dwa_rotator u_rotator (
        .code     (code_i),
        .ptr      (ptr_r),
        .mask     (rot_mask_s),
        .ptr_next (rot_ptr_next_s)
    );

    assign mode_s = dem_mode_e'(mode_i);

    // Next-state selection; an idle cycle holds the DAC drive and pointer.
    always_comb begin
        elements_nxt_s = elements_r;
        level_nxt_s    = level_r;
        ptr_nxt_s      = ptr_r;
        valid_nxt_s    = 1'b0;
        if (valid_i) begin
            valid_nxt_s = 1'b1;
            level_nxt_s = INPUT_WIDTH'(code_i) << LEVEL_SHIFT;
            case (mode_s)
                DEM_DWA: begin
                    elements_nxt_s = rot_mask_s;
                    ptr_nxt_s      = rot_ptr_next_s;
                end
                DEM_THERM: begin
                    // Bypass keeps the pointer so DWA resumes where it left off.
                    elements_nxt_s = therm_mask(code_i);
                    ptr_nxt_s      = ptr_r;
                end
                default: begin
                    elements_nxt_s = '0;
                    ptr_nxt_s      = ptr_r;
                end
            endcase
        end else begin
            elements_nxt_s = elements_r;
            level_nxt_s    = level_r;
            ptr_nxt_s      = ptr_r;
        end
    end

    // Output and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            elements_r <= '0;
            level_r    <= '0;
            ptr_r      <= '0;
            valid_r    <= 1'b0;
        end else begin
            elements_r <= elements_nxt_s;
            level_r    <= level_nxt_s;
            ptr_r      <= ptr_nxt_s;
            valid_r    <= valid_nxt_s;
        end
    end

    assign elements_o = elements_r;
    assign level_o    = level_r;
    assign ptr_o      = ptr_r;
    assign valid_o    = valid_r;

endmodule

// File: tb/tb_dwa_element_selector.sv
// Self-checking bench for dwa_element_selector: directed scenarios plus
// randomized traffic against a modulo-arithmetic reference model.
module tb_dwa_element_selector;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [2:0]  code;
    logic        mode;
    logic [6:0]  elements;
    logic        valid_out;
    logic [15:0] level;
    logic [2:0]  ptr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int         m_ptr;
    logic [6:0] m_elems;
    int         m_level;
    logic       m_valid;

    dwa_element_selector dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_in),
        .code_i     (code),
        .mode_i     (mode),
        .elements_o (elements),
        .valid_o    (valid_out),
        .level_o    (level),
        .ptr_o      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input int c, input logic m);
        rst      = r;
        valid_in = v;
        code     = 3'(c);
        mode     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_elems = 7'd0; m_level = 0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic v, input int c, input logic m);
        if (!v) begin
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_level = c * 8192;
            m_elems = 7'd0;
            for (int j = 0; j < c; j++) begin
                if (m) m_elems[j] = 1'b1;
                else   m_elems[(m_ptr + j) % 7] = 1'b1;
            end
            if (!m) m_ptr = (m_ptr + c) % 7;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5, 1'b0);
        total_cnt++;
        if ({elements, valid_out, level, ptr} !== {7'd0, 1'b0, 16'd0, 3'd0})
            $display("FAIL reset: got elem=%b v=%b lvl=%0d ptr=%0d, required all zero",
                     elements, valid_out, level, ptr);
        else pass_cnt++;
    endtask

    task automatic test_dwa_directed();
        int         codes[7]  = '{3, 3, 3, 7, 0, 5, 1};
        logic       modes[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [6:0] exp_e[7]  = '{7'b0000111, 7'b0111000, 7'b1000011, 7'b1111111,
                                  7'b0000000, 7'b0011111, 7'b0000100};
        int         exp_p[7]  = '{3, 6, 2, 2, 2, 2, 3};
        int         exp_l[7]  = '{24576, 24576, 24576, 57344, 0, 40960, 8192};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, codes[i], modes[i]);
            total_cnt++;
            if (elements !== exp_e[i] || ptr !== 3'(exp_p[i]) || level !== 16'(exp_l[i]) || valid_out !== 1'b1)
                $display("FAIL dwa_step%0d: got elem=%b ptr=%0d lvl=%0d v=%b, required elem=%b ptr=%0d lvl=%0d v=1",
                         i, elements, ptr, level, valid_out, exp_e[i], exp_p[i], exp_l[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b1, 4, 1'b0);
        total_cnt++;
        if (elements !== 7'b1111000 || ptr !== 3'd0 || level !== 16'd32768 || valid_out !== 1'b1)
            $display("FAIL hold_load: got elem=%b ptr=%0d lvl=%0d v=%b, required 1111000/0/32768/1",
                     elements, ptr, level, valid_out);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 1));
            total_cnt++;
            if (elements !== 7'b1111000 || ptr !== 3'd0 || level !== 16'd32768 || valid_out !== 1'b0)
                $display("FAIL hold_idle%0d: got elem=%b ptr=%0d lvl=%0d v=%b, required 1111000/0/32768/0",
                         i, elements, ptr, level, valid_out);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b1, 1, 1'b0);
        step(1'b1, 1'b1, 2, 1'b0);
        total_cnt++;
        if (elements !== 7'b0000110 || ptr !== 3'd3)
            $display("FAIL midstream_pre: got elem=%b ptr=%0d, required 0000110/3", elements, ptr);
        else pass_cnt++;
        step(1'b0, 1'b1, 3, 1'b0);
        total_cnt++;
        if ({elements, valid_out, level, ptr} !== {7'd0, 1'b0, 16'd0, 3'd0})
            $display("FAIL midstream_reset: got elem=%b v=%b lvl=%0d ptr=%0d, required all zero",
                     elements, valid_out, level, ptr);
        else pass_cnt++;
        step(1'b1, 1'b1, 2, 1'b0);
        total_cnt++;
        if (elements !== 7'b0000011 || ptr !== 3'd2 || level !== 16'd16384 || valid_out !== 1'b1)
            $display("FAIL midstream_release: got elem=%b ptr=%0d lvl=%0d v=%b, required 0000011/2/16384/1",
                     elements, ptr, level, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int  cnt[7];
        int  mn, mx, c;
        logic v, m;
        int  errs = 0;
        step(1'b0, 1'b0, 0, 1'b0);
        model_reset();
        for (int i = 0; i < 7; i++) cnt[i] = 0;
        for (int n = 0; n < 1200; n++) begin
            v = ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 7);
            m = (n >= 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            step(1'b1, v, c, m);
            model_step(v, c, m);
            total_cnt++;
            if (elements !== m_elems || ptr !== 3'(m_ptr) || level !== 16'(m_level) || valid_out !== m_valid) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random%0d: got elem=%b ptr=%0d lvl=%0d v=%b, required elem=%b ptr=%0d lvl=%0d v=%b",
                             n, elements, ptr, level, valid_out, m_elems, m_ptr, m_level, m_valid);
            end else pass_cnt++;
            if (valid_out) begin
                total_cnt++;
                if ($countones(elements) != c) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL popcount%0d: got %0d ones, required %0d", n, $countones(elements), c);
                end else pass_cnt++;
                if (n < 1000)
                    for (int i = 0; i < 7; i++) cnt[i] += int'(elements[i]);
            end
        end
        mn = cnt[0]; mx = cnt[0];
        for (int i = 1; i < 7; i++) begin
            if (cnt[i] < mn) mn = cnt[i];
            if (cnt[i] > mx) mx = cnt[i];
        end
        total_cnt++;
        if (mx - mn > 1)
            $display("FAIL balance: got element on-count spread %0d (min %0d max %0d), required <= 1", mx - mn, mn, mx);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; code = 3'd0; mode = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_dwa_directed();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dwa_element_selector.md
# dwa_element_selector

Dynamic-element-matching selector for the unit-element DAC. It consumes the quantizer's OUTPUT_WIDTH-bit code and drives one enable per unit element, rotating the start position by data-weighted averaging (DWA) so element mismatch is first-order noise-shaped. It sits directly downstream of the quantizer: the quantizer encodes a sample to a code, and this block decodes the code into element enables. It also reports the ideal reconstructed level for loop monitoring.

## Interface
Parameters (from lib_switchblock_pkg):
- INPUT_WIDTH, 16, width of reconstructed level (matches quantizer input width)
- OUTPUT_WIDTH, 3, width of quantizer code
- NUM_ELEMENTS, 2**OUTPUT_WIDTH-1 = 7, unit elements; code k enables exactly k elements
- PTR_WIDTH, $clog2(NUM_ELEMENTS) = 3, rotation pointer width

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- valid_i  in  1  code_i valid this cycle
- code_i  in  OUTPUT_WIDTH  quantizer code, 0..7
- mode_i  in  1  0 = DWA rotate, 1 = static thermometer (bypass)
- elements_o  out  NUM_ELEMENTS  unit-element enables, bit i drives element i
- valid_o  out  1  elements_o updated this cycle
- level_o  out  INPUT_WIDTH  ideal level = code × 2**(INPUT_WIDTH-OUTPUT_WIDTH)
- ptr_o  out  PTR_WIDTH  current rotation pointer (next start element)

## Operation
- Registered state: ptr (0..NUM_ELEMENTS-1), elements_o, level_o, valid_o.
- DWA mode, valid_i=1, code k: enable elements ptr, ptr+1, …, ptr+k-1 mod NUM_ELEMENTS; ptr_next = (ptr+k) mod NUM_ELEMENTS.
- Modulo arithmetic: sum = ptr + k in PTR_WIDTH+1 bits (max 6+7=13); if sum ≥ NUM_ELEMENTS subtract NUM_ELEMENTS once. No division.
- Element mask: thermometer of k bits (bits k-1..0 set) rotated left by ptr within NUM_ELEMENTS bits.
- k=0: elements all zero, ptr unchanged. k=NUM_ELEMENTS: all ones, ptr unchanged (wraps to itself).
- Thermometer mode (mode_i=1): elements = bits k-1..0 set; ptr held, not reset. Switching back to DWA resumes from held ptr.
- valid_i=0: elements_o, level_o, ptr held (DAC sample-and-hold); valid_o=0.
- level_o = k << (INPUT_WIDTH-OUTPUT_WIDTH), unsigned; k=7 → 57344.
- Invariant: popcount(elements_o) equals the last accepted code at all times after first valid.

## Timing
- Latency 1 cycle: code accepted at edge N appears on elements_o/level_o/valid_o after edge N; valid_o is a 1-cycle pulse per accepted code.
- ptr_o shows the post-update pointer in the same cycle as the corresponding elements_o.
- Back-to-back valid_i every cycle supported, no bubbles, no backpressure.
- Reset (rst_i=0 at a rising edge): elements_o=0, level_o=0, valid_o=0, ptr_o=0, regardless of valid_i. A code presented during reset is dropped. Reset mid-stream takes priority at that edge; the first valid after release starts at element 0.
- mode_i is sampled with valid_i at the same edge.

## Structure
- lib_switchblock_pkg: NUM_ELEMENTS, PTR_WIDTH, LEVEL_SHIFT = INPUT_WIDTH-OUTPUT_WIDTH, typedef dem_mode_e {DEM_DWA, DEM_THERM}, typedef elem_vec_t logic [NUM_ELEMENTS-1:0].
- One sub-module: dwa_rotator — combinational; inputs code and ptr; outputs rotated mask and ptr_next. Top holds registers, mode mux and level computation.

## Test plan
- Reset then DWA codes 3,3,3 → elements 7'b0000111/ptr 3, 7'b0111000/ptr 6, 7'b1000011/ptr 2 (wrap); level_o 24576 each.
- From ptr 2: code 7 → 7'b1111111, ptr stays 2; code 0 → 7'b0000000, ptr stays 2, level_o 0.
- mode_i=1 code 5 → 7'b0011111, ptr held at 2; then mode_i=0 code 1 → 7'b0000100, ptr 3.
- valid_i low for 4 cycles after a code-4 word → elements_o/level_o frozen, valid_o=0, ptr unchanged.
- Reset asserted one cycle inside a continuous valid stream → next edge all outputs 0, ptr 0; first code 2 after release → 7'b0000011.
- 1000 random codes, random valid: popcount(elements_o) == code on every valid_o, and each element's on-count differs from every other's by ≤1 in DWA mode.
